// File: rtl/tetris_piece_control_unit.sv
// Tetris game-control core: tetromino cell decoder, game-flow FSM, 16-bit LFSR piece source.
// Latency: cell coordinates are combinational; FSM strobes follow the state register; rand_out is registered.
// Backpressure: none; the FSM only advances on step, the LFSR advances every clock.
module tetris_piece_control_unit #(
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       step,
    input  logic       start_game,
    input  logic       filled_under,
    input  logic       overflow,
    input  logic [3:0] x,
    input  logic [4:0] y,
    input  logic [2:0] block_type,
    output logic [3:0] x1,
    output logic [3:0] x2,
    output logic [3:0] x3,
    output logic [3:0] x4,
    output logic [4:0] y1,
    output logic [4:0] y2,
    output logic [4:0] y3,
    output logic [4:0] y4,
    output logic       load_block,
    output logic       drop_block,
    output logic       update_board_state,
    output logic       game_over,
    output logic [3:0] rand_out
);

    // Offsets are added modulo the coordinate width, so -1 is all ones.
    localparam logic [3:0] DX_P0 = 4'd0;
    localparam logic [3:0] DX_P1 = 4'd1;
    localparam logic [3:0] DX_P2 = 4'd2;
    localparam logic [3:0] DX_M1 = 4'hF;
    localparam logic [4:0] DY_P0 = 5'd0;
    localparam logic [4:0] DY_M1 = 5'h1F;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        DROP   = 3'd2,
        UPDATE = 3'd3,
        CHECK  = 3'd4,
        OVER   = 3'd5
    } state_t;

    state_t      state;
    state_t      next_state;
    logic [15:0] lfsr;
    logic        lfsr_fb;

    logic [3:0] dx2, dx3, dx4;
    logic [4:0] dy2, dy3, dy4;

    // Per-type offsets of cells 2..4 relative to the centre cell; types 0 and 7 are both O.
    always_comb begin
        dx2 = DX_P1; dy2 = DY_P0;
        dx3 = DX_P0; dy3 = DY_M1;
        dx4 = DX_P1; dy4 = DY_M1;
        case (block_type)
            3'd1: begin // I
                dx2 = DX_M1; dy2 = DY_P0;
                dx3 = DX_P1; dy3 = DY_P0;
                dx4 = DX_P2; dy4 = DY_P0;
            end
            3'd2: begin // T
                dx2 = DX_M1; dy2 = DY_P0;
                dx3 = DX_P1; dy3 = DY_P0;
                dx4 = DX_P0; dy4 = DY_M1;
            end
            3'd3: begin // S
                dx2 = DX_P1; dy2 = DY_P0;
                dx3 = DX_P0; dy3 = DY_M1;
                dx4 = DX_M1; dy4 = DY_M1;
            end
            3'd4: begin // Z
                dx2 = DX_M1; dy2 = DY_P0;
                dx3 = DX_P0; dy3 = DY_M1;
                dx4 = DX_P1; dy4 = DY_M1;
            end
            3'd5: begin // J
                dx2 = DX_M1; dy2 = DY_P0;
                dx3 = DX_P1; dy3 = DY_P0;
                dx4 = DX_P1; dy4 = DY_M1;
            end
            3'd6: begin // L
                dx2 = DX_M1; dy2 = DY_P0;
                dx3 = DX_P1; dy3 = DY_P0;
                dx4 = DX_M1; dy4 = DY_M1;
            end
            default: begin // O (types 0 and 7)
                dx2 = DX_P1; dy2 = DY_P0;
                dx3 = DX_P0; dy3 = DY_M1;
                dx4 = DX_P1; dy4 = DY_M1;
            end
        endcase
    end

    assign x1 = x;
    assign y1 = y;
    assign x2 = x + dx2;
    assign y2 = y + dy2;
    assign x3 = x + dx3;
    assign y3 = y + dy3;
    assign x4 = x + dx4;
    assign y4 = y + dy4;

    // State register: reset wins over step, otherwise advance only on the fall tick.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else if (step) begin
            state <= next_state;
        end
    end

    // Next-state and Moore strobes; each strobe is tied to exactly one state.
    always_comb begin
        next_state         = state;
        load_block         = 1'b0;
        drop_block         = 1'b0;
        update_board_state = 1'b0;
        game_over          = 1'b0;
        case (state)
            IDLE: begin
                if (start_game) next_state = LOAD;
            end
            LOAD: begin
                load_block = 1'b1;
                next_state = DROP;
            end
            DROP: begin
                drop_block = 1'b1;
                if (filled_under) next_state = UPDATE;
            end
            UPDATE: begin
                update_board_state = 1'b1;
                next_state         = CHECK;
            end
            CHECK: begin
                next_state = overflow ? OVER : LOAD;
            end
            OVER: begin
                game_over = 1'b1;
                if (start_game) next_state = LOAD;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    assign lfsr_fb = lfsr[15] ^ lfsr[14] ^ lfsr[12] ^ lfsr[3];

    // Free-running Fibonacci LFSR; a nonzero seed keeps it out of the all-zero lock-up state.
    always_ff @(posedge clock) begin
        if (reset) begin
            lfsr <= LFSR_SEED;
        end else begin
            lfsr <= {lfsr[14:0], lfsr_fb};
        end
    end

    assign rand_out = lfsr[3:0];

endmodule

// File: tb/tb_tetris_piece_control_unit.sv
// Directed bench for tetris_piece_control_unit: LFSR sequence, cell decoder, game-flow FSM.
// Inputs are driven on the falling edge, outputs sampled on the falling edge after each rising edge.
// Strobes are checked as one packed nibble {load, drop, update, game_over}.
module tb_tetris_piece_control_unit;

    logic       clock;
    logic       reset;
    logic       step;
    logic       start_game;
    logic       filled_under;
    logic       overflow;
    logic [3:0] x;
    logic [4:0] y;
    logic [2:0] block_type;
    logic [3:0] x1, x2, x3, x4;
    logic [4:0] y1, y2, y3, y4;
    logic       load_block;
    logic       drop_block;
    logic       update_board_state;
    logic       game_over;
    logic [3:0] rand_out;

    int vectors;
    int miscompares;

    tetris_piece_control_unit #(.LFSR_SEED(16'hACE1)) dut (
        .clock              (clock),
        .reset              (reset),
        .step               (step),
        .start_game         (start_game),
        .filled_under       (filled_under),
        .overflow           (overflow),
        .x                  (x),
        .y                  (y),
        .block_type         (block_type),
        .x1                 (x1),
        .x2                 (x2),
        .x3                 (x3),
        .x4                 (x4),
        .y1                 (y1),
        .y2                 (y2),
        .y3                 (y3),
        .y4                 (y4),
        .load_block         (load_block),
        .drop_block         (drop_block),
        .update_board_state (update_board_state),
        .game_over          (game_over),
        .rand_out           (rand_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Strobe nibble encodings
    localparam logic [3:0] S_NONE = 4'b0000;
    localparam logic [3:0] S_LOAD = 4'b1000;
    localparam logic [3:0] S_DROP = 4'b0100;
    localparam logic [3:0] S_UPD  = 4'b0010;
    localparam logic [3:0] S_OVER = 4'b0001;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    function automatic logic [3:0] strobes();
        return {load_block, drop_block, update_board_state, game_over};
    endfunction

    // Apply a piece and compare all four cells against hand-computed coordinates.
    task automatic geo(input string tag, input logic [2:0] t, input logic [3:0] cx, input logic [4:0] cy,
                       input logic [3:0] ex2, input logic [4:0] ey2,
                       input logic [3:0] ex3, input logic [4:0] ey3,
                       input logic [3:0] ex4, input logic [4:0] ey4);
        block_type = t;
        x          = cx;
        y          = cy;
        #1;
        chk({tag, "_c1"}, {23'd0, x1, y1}, {23'd0, cx, cy});
        chk({tag, "_c2"}, {23'd0, x2, y2}, {23'd0, ex2, ey2});
        chk({tag, "_c3"}, {23'd0, x3, y3}, {23'd0, ex3, ey3});
        chk({tag, "_c4"}, {23'd0, x4, y4}, {23'd0, ex4, ey4});
    endtask

    initial begin
        vectors      = 0;
        miscompares  = 0;
        reset        = 1'b1;
        step         = 1'b0;
        start_game   = 1'b0;
        filled_under = 1'b0;
        overflow     = 1'b0;
        x            = 4'd0;
        y            = 5'd0;
        block_type   = 3'd0;

        // Reset state and LFSR sequence ACE1 -> 59C3 -> B386
        @(negedge clock);
        tick();
        chk("rst_strobes", {28'd0, strobes()}, {28'd0, S_NONE});
        chk("rst_rand", {28'd0, rand_out}, 32'h1);
        reset = 1'b0;
        tick();
        chk("lfsr_1", {28'd0, rand_out}, 32'h3);
        tick();
        chk("lfsr_2", {28'd0, rand_out}, 32'h6);

        // Cell decoder
        geo("geo_I",  3'd1, 4'd4, 5'd19, 4'd3, 5'd19, 4'd5, 5'd19, 4'd6, 5'd19);
        geo("geo_T",  3'd2, 4'd4, 5'd19, 4'd3, 5'd19, 4'd5, 5'd19, 4'd4, 5'd18);
        geo("geo_O7", 3'd7, 4'd4, 5'd19, 4'd5, 5'd19, 4'd4, 5'd18, 4'd5, 5'd18);
        geo("geo_O0", 3'd0, 4'd4, 5'd19, 4'd5, 5'd19, 4'd4, 5'd18, 4'd5, 5'd18);
        geo("geo_Sw", 3'd3, 4'd0, 5'd0,  4'd1, 5'd0,  4'd0, 5'd31, 4'd15, 5'd31);
        geo("geo_Z",  3'd4, 4'd5, 5'd10, 4'd4, 5'd10, 4'd5, 5'd9,  4'd6, 5'd9);
        geo("geo_J",  3'd5, 4'd5, 5'd10, 4'd4, 5'd10, 4'd6, 5'd10, 4'd6, 5'd9);
        geo("geo_L",  3'd6, 4'd5, 5'd10, 4'd4, 5'd10, 4'd6, 5'd10, 4'd4, 5'd9);

        // start_game without step must not leave IDLE
        start_game = 1'b1;
        step       = 1'b0;
        tick();
        chk("idle_nostep", {28'd0, strobes()}, {28'd0, S_NONE});

        // Normal flow
        step = 1'b1;
        tick();
        chk("flow_load", {28'd0, strobes()}, {28'd0, S_LOAD});
        start_game = 1'b0;
        tick();
        chk("flow_drop", {28'd0, strobes()}, {28'd0, S_DROP});
        start_game   = 1'b1;  // ignored outside IDLE/OVER
        filled_under = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("flow_falling", {28'd0, strobes()}, {28'd0, S_DROP});
        end
        start_game = 1'b0;

        // Hold with step low while blocked below
        step         = 1'b0;
        filled_under = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (i == 0 || i == 9) chk("hold_drop", {28'd0, strobes()}, {28'd0, S_DROP});
        end

        step = 1'b1;
        tick();
        chk("flow_update", {28'd0, strobes()}, {28'd0, S_UPD});
        filled_under = 1'b0;
        overflow     = 1'b1;  // ignored in UPDATE
        tick();
        chk("flow_check", {28'd0, strobes()}, {28'd0, S_NONE});
        overflow = 1'b0;
        tick();
        chk("flow_reload", {28'd0, strobes()}, {28'd0, S_LOAD});

        // Game over path
        tick();
        chk("go_drop", {28'd0, strobes()}, {28'd0, S_DROP});
        filled_under = 1'b1;
        tick();
        chk("go_update", {28'd0, strobes()}, {28'd0, S_UPD});
        filled_under = 1'b0;
        tick();
        chk("go_check", {28'd0, strobes()}, {28'd0, S_NONE});
        overflow = 1'b1;
        tick();
        chk("go_over", {28'd0, strobes()}, {28'd0, S_OVER});
        overflow = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("go_hold", {28'd0, strobes()}, {28'd0, S_OVER});
        end
        start_game = 1'b1;
        tick();
        chk("go_restart", {28'd0, strobes()}, {28'd0, S_LOAD});
        start_game = 1'b0;
        tick();
        chk("rst_pre_drop", {28'd0, strobes()}, {28'd0, S_DROP});

        // Reset in DROP beats step and filled_under
        filled_under = 1'b1;
        reset        = 1'b1;
        tick();
        chk("rst_drop_strobes", {28'd0, strobes()}, {28'd0, S_NONE});
        chk("rst_drop_rand", {28'd0, rand_out}, 32'h1);
        reset        = 1'b0;
        step         = 1'b0;
        filled_under = 1'b0;
        tick();
        chk("rst_lfsr_1", {28'd0, rand_out}, 32'h3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
